// File: rtl/aes128_pipelined_decrypt.sv
// aes128_pipelined_decrypt: fully pipelined AES-128 inverse cipher, one block per clock, 11-cycle latency
// Ports: clk, reset (async, active-high), valid_in, ciphertext[127:0], key[127:0] in;
//        valid_output, plaintext[127:0] out. Byte 0 of every 128-bit bus is bits [127:120].
module aes128_pipelined_decrypt (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         valid_output,
  output logic [127:0] plaintext
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  // Multiplicative inverse as x^254 through an addition chain; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2 = gmul(x, x);
    x3 = gmul(x2, x);
    x12 = gmul(gmul(x3, x3), gmul(x3, x3));
    x15 = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < 10; i++)
      if (i < r) c = xtime(c);
    return c;
  endfunction
  function automatic logic [127:0] fwd_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  // Undo one key-expansion round: words 3..1 first, then word 0 from the recovered word 3.
  function automatic logic [127:0] inv_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] o0, o1, o2, o3;
    o3 = k[31:0] ^ k[63:32];
    o2 = k[63:32] ^ k[95:64];
    o1 = k[95:64] ^ k[127:96];
    o0 = k[127:96] ^ sub_rot_word(o3) ^ {rc, 24'h0};
    return {o0, o1, o2, o3};
  endfunction
  // Row r rotates right by r columns, fused with the inverse S-box.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction
  logic [127:0] st [10];
  logic [127:0] k [10];
  logic [127:0] rkn [10];
  logic [127:0] rk10;
  logic [9:0] v;
  always_comb begin
    rk10 = key;
    for (int r = 1; r <= 10; r++) rk10 = fwd_round(rk10, rcon(r));
  end
  // rkn[s] is the round key stage s+1 consumes: k[s] holds rk(10-s), so rkn[s] = rk(9-s).
  always_comb
    for (int s = 0; s < 10; s++) rkn[s] = inv_round(k[s], rcon(10 - s));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < 10; s++) begin
        st[s] <= '0;
        k[s] <= '0;
      end
      v <= '0;
      valid_output <= 1'b0;
      plaintext <= '0;
    end else begin
      st[0] <= ciphertext ^ rk10;
      k[0] <= rk10;
      v <= {v[8:0], valid_in};
      for (int s = 1; s < 10; s++) begin
        st[s] <= inv_mix(inv_shift_sub(st[s-1]) ^ rkn[s-1]);
        k[s] <= rkn[s-1];
      end
      valid_output <= v[9];
      if (v[9]) plaintext <= inv_shift_sub(st[9]) ^ rkn[9];
    end
endmodule

// File: tb/tb_aes128_pipelined_decrypt.sv
// tb_aes128_pipelined_decrypt: directed known-answer checks of the pipelined AES-128 decryptor
module tb_aes128_pipelined_decrypt;
  logic clk = 1'b0;
  logic reset;
  logic valid_in;
  logic [127:0] ciphertext, key;
  logic valid_output;
  logic [127:0] plaintext;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] K1 = 128'h0;
  localparam logic [127:0] C1 = 128'hc7d12419489e3b6233a2c5a7f4563172;
  localparam logic [127:0] P1 = 128'h00000101030307070f0f1f1f3f3f7f7f;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] JUNK_C = 128'hdeadbeef0badf00d123456789abcdef0;
  localparam logic [127:0] JUNK_K = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  aes128_pipelined_decrypt dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .ciphertext(ciphertext),
    .key(key),
    .valid_output(valid_output),
    .plaintext(plaintext)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_out(input string tag, input logic vo, input logic [127:0] pt);
    check({tag, "_valid"}, {127'b0, valid_output}, {127'b0, vo});
    check({tag, "_pt"}, plaintext, pt);
  endtask
  initial begin
    reset = 1'b1;
    valid_in = 1'b0;
    ciphertext = JUNK_C;
    key = JUNK_K;
    #2;
    check_out("reset_async", 1'b0, '0);
    tick(3);
    check_out("reset_held", 1'b0, '0);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick(1);
      check_out("idle_after_reset", 1'b0, '0);
    end
    ciphertext = C1;
    key = K1;
    valid_in = 1'b1;
    tick(10);
    check_out("v1_before_latency", 1'b0, '0);
    tick(1);
    check_out("v1_first", 1'b1, P1);
    tick(9);
    check_out("v1_at_20", 1'b1, P1);
    valid_in = 1'b0;
    ciphertext = JUNK_C;
    key = JUNK_K;
    tick(12);
    check_out("v1_drained_hold", 1'b0, P1);
    ciphertext = C2;
    key = K2;
    valid_in = 1'b1;
    tick(1);
    ciphertext = C1;
    key = K1;
    tick(1);
    valid_in = 1'b0;
    ciphertext = JUNK_C;
    key = JUNK_K;
    tick(8);
    check_out("b2b_pre", 1'b0, P1);
    tick(1);
    check_out("b2b_first_v2", 1'b1, P2);
    tick(1);
    check_out("b2b_second_v1", 1'b1, P1);
    tick(1);
    check_out("b2b_after", 1'b0, P1);
    ciphertext = C2;
    key = K2;
    valid_in = 1'b1;
    tick(1);
    valid_in = 1'b0;
    ciphertext = JUNK_C;
    key = JUNK_K;
    tick(9);
    check_out("pulse_pre", 1'b0, P1);
    tick(1);
    check_out("pulse_out", 1'b1, P2);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_out("pulse_hold", 1'b0, P2);
    end
    ciphertext = C1;
    key = K1;
    valid_in = 1'b1;
    tick(12);
    check_out("stream_before_reset", 1'b1, P1);
    valid_in = 1'b0;
    ciphertext = JUNK_C;
    key = JUNK_K;
    tick(5);
    check_out("inflight_before_reset", 1'b1, P1);
    reset = 1'b1;
    #1;
    check_out("midstream_reset_async", 1'b0, '0);
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick(1);
      check_out("flushed_after_reset", 1'b0, '0);
    end
    ciphertext = C2;
    key = K2;
    valid_in = 1'b1;
    tick(1);
    valid_in = 1'b0;
    ciphertext = JUNK_C;
    tick(9);
    check_out("post_reset_pre", 1'b0, '0);
    tick(1);
    check_out("post_reset_out", 1'b1, P2);
    tick(1);
    check_out("post_reset_hold", 1'b0, P2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
